// File: rtl/zoom_pkg.sv
// Shared opcodes, FSM encoding, job descriptor and per-pixel read counts for the zoom engine.
package zoom_pkg;

  // Command opcodes
  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_COPY    = 3'b001;
  localparam logic [2:0] OP_ILLEGAL = 3'b010;
  localparam logic [2:0] OP_ZIN     = 3'b011;
  localparam logic [2:0] OP_ZIN_ALT = 3'b100;
  localparam logic [2:0] OP_ZAVG    = 3'b101;
  localparam logic [2:0] OP_ZDEC    = 3'b110;
  localparam logic [2:0] OP_RESET   = 3'b111;

  // Per-pixel source read counts
  localparam logic [2:0] RD_CNT_NONE = 3'd0;
  localparam logic [2:0] RD_CNT_ONE  = 3'd1;
  localparam logic [2:0] RD_CNT_AVG  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    MODE_COPY,
    MODE_ZIN,
    MODE_AVG,
    MODE_DEC
  } zoom_mode_e;

  // What the accepted command does to the level and whether it is rejected
  typedef enum logic [2:0] {
    K_NOP,
    K_ERR,
    K_COPY,
    K_RESET,
    K_ZIN,
    K_ZOUT
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    zoom_mode_e mode;
  } job_t;

  // Number of source reads needed for one destination pixel
  function automatic logic [2:0] read_count(input zoom_mode_e mode, input logic inner);
    if (!inner) return RD_CNT_NONE;
    return (mode == MODE_AVG) ? RD_CNT_AVG : RD_CNT_ONE;
  endfunction

endpackage

// File: rtl/zoom_addr_gen.sv
// Combinational destination-coordinate to source-address mapping for all zoom modes.
module zoom_addr_gen
  import zoom_pkg::*;
#(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned XW     = 9,
  parameter int unsigned YW     = 8
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  zoom_mode_e        mode,
  input  logic [1:0]        ridx,
  output logic [ADDR_W-1:0] addr,
  output logic              inner
);

  localparam logic [ADDR_W-1:0] QX    = ADDR_W'(IMG_W / 4);
  localparam logic [ADDR_W-1:0] QY    = ADDR_W'(IMG_H / 4);
  localparam logic [ADDR_W-1:0] X3    = ADDR_W'((3 * IMG_W) / 4);
  localparam logic [ADDR_W-1:0] Y3    = ADDR_W'((3 * IMG_H) / 4);
  localparam logic [ADDR_W-1:0] WIDTH = ADDR_W'(IMG_W);

  logic [ADDR_W-1:0] xa;
  logic [ADDR_W-1:0] ya;
  logic [ADDR_W-1:0] sx;
  logic [ADDR_W-1:0] sy;

  // Source coordinate selection; ridx bit0 steps x, bit1 steps y in the 2x2 average
  always_comb begin
    xa    = ADDR_W'(x);
    ya    = ADDR_W'(y);
    inner = 1'b1;
    sx    = xa;
    sy    = ya;
    case (mode)
      MODE_ZIN: begin
        sx = QX + (xa >> 1);
        sy = QY + (ya >> 1);
      end
      MODE_AVG, MODE_DEC: begin
        inner = (xa >= QX) && (xa < X3) && (ya >= QY) && (ya < Y3);
        sx    = (xa - QX) << 1;
        sy    = (ya - QY) << 1;
        if (mode == MODE_AVG) begin
          sx = sx + ADDR_W'(ridx[0]);
          sy = sy + ADDR_W'(ridx[1]);
        end
      end
      default: ;
    endcase
    addr = sy * WIDTH + sx;
  end

endmodule

// File: rtl/zoom_engine.sv
// Frame zoom engine: reads a source image, writes a zoomed/copied destination image pixel by pixel.
module zoom_engine
  import zoom_pkg::*;
#(
  parameter int unsigned      IMG_W   = 320,
  parameter int unsigned      IMG_H   = 240,
  parameter int unsigned      PIX_W   = 8,
  parameter int unsigned      ADDR_W  = 17,
  parameter int unsigned      RD_LAT  = 2,
  parameter int unsigned      MAX_IN  = 2,
  parameter int unsigned      MAX_OUT = 2,
  parameter logic [PIX_W-1:0] BORDER  = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              zoom_max,
  output logic              zoom_min
);

  localparam int unsigned XW    = $clog2(IMG_W);
  localparam int unsigned YW    = $clog2(IMG_H);
  localparam int unsigned ACC_W = PIX_W + 2;
  localparam int unsigned LVL_W = 8;

  localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(MAX_IN);
  localparam logic [LVL_W-1:0]  LVL_MIN  = LVL_W'(-int'(MAX_OUT));
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);

  state_e              state_q, state_d;
  job_t                job_q, job_d, dec_job;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic [2:0]          ridx_q, ridx_d;
  logic [2:0]          ret_cnt_q, ret_cnt_d;
  logic [2:0]          n_q, n_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [RD_LAT-1:0]   ret_pipe_q, ret_pipe_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]    wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                zoom_max_q, zoom_max_d;
  logic                zoom_min_q, zoom_min_d;
  logic [ADDR_W-1:0]   gen_addr;
  logic                gen_inner;
  logic                ret_valid;
  logic                last_pix;

  assign ret_valid = ret_pipe_q[RD_LAT-1];
  assign last_pix  = (pix_q == PIX_LAST);

  zoom_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_addr_gen (
    .x     (x_d),
    .y     (y_d),
    .mode  (job_d.mode),
    .ridx  (ridx_d[1:0]),
    .addr  (gen_addr),
    .inner (gen_inner)
  );

  // Command decode, including rejection of zooms already at their limit
  always_comb begin
    dec_job.kind = K_ERR;
    dec_job.mode = MODE_COPY;
    case (cmd_op)
      OP_NOP:   dec_job.kind = K_NOP;
      OP_COPY:  dec_job.kind = K_COPY;
      OP_RESET: dec_job.kind = K_RESET;
      OP_ZIN, OP_ZIN_ALT: begin
        if (level_q != LVL_MAX) begin
          dec_job.kind = K_ZIN;
          dec_job.mode = MODE_ZIN;
        end
      end
      OP_ZAVG, OP_ZDEC: begin
        if (level_q != LVL_MIN) begin
          dec_job.kind = K_ZOUT;
          dec_job.mode = (cmd_op == OP_ZAVG) ? MODE_AVG : MODE_DEC;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = (dec_job.kind == K_NOP || dec_job.kind == K_ERR) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (n_q == RD_CNT_NONE)              state_d = ST_WRITE;
        else if (ridx_q == n_q - 3'd1)       state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ret_valid && ret_cnt_q == n_q - 3'd1) state_d = ST_WRITE;
      end
      ST_WRITE:  state_d = last_pix ? ST_FINISH : ST_ISSUE;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pixel walk, read tracking, accumulation and level update
  always_comb begin
    job_d      = job_q;
    x_d        = x_q;
    y_d        = y_q;
    pix_d      = pix_q;
    ridx_d     = ridx_q;
    ret_cnt_d  = ret_cnt_q;
    acc_d      = acc_q;
    level_d    = level_q;
    ret_pipe_d = (ret_pipe_q << 1) | RD_LAT'(rd_en_q);
    if (ret_valid) begin
      acc_d     = acc_q + ACC_W'(rd_data);
      ret_cnt_d = ret_cnt_q + 3'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          job_d     = dec_job;
          x_d       = '0;
          y_d       = '0;
          pix_d     = '0;
          ridx_d    = '0;
          ret_cnt_d = '0;
          acc_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (n_q != RD_CNT_NONE) ridx_d = ridx_q + 3'd1;
      end
      ST_WRITE: begin
        ridx_d    = '0;
        ret_cnt_d = '0;
        acc_d     = '0;
        if (!last_pix) begin
          pix_d = pix_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_FINISH: begin
        case (job_q.kind)
          K_ZIN:   level_d = level_q + LVL_W'(1);
          K_ZOUT:  level_d = level_q - LVL_W'(1);
          K_RESET: level_d = '0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Registered outputs, computed from the upcoming state
  always_comb begin
    n_d         = n_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (state_d == ST_ISSUE && state_q != ST_ISSUE) n_d = read_count(job_d.mode, gen_inner);
    rd_en_d     = (state_d == ST_ISSUE) && (n_d != RD_CNT_NONE);
    wr_en_d     = (state_d == ST_WRITE);
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
    done_d      = (state_d == ST_FINISH);
    err_d       = done_d && (job_d.kind == K_ERR);
    zoom_max_d  = (level_q == LVL_MAX);
    zoom_min_d  = (level_q == LVL_MIN);
    if (rd_en_d) rd_addr_d = gen_addr;
    if (wr_en_d) begin
      wr_addr_d = pix_q;
      case (n_q)
        RD_CNT_NONE: wr_data_d = BORDER;
        RD_CNT_AVG:  wr_data_d = acc_d[ACC_W-1:2];
        default:     wr_data_d = acc_d[PIX_W-1:0];
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      job_q.kind  <= K_NOP;
      job_q.mode  <= MODE_COPY;
      x_q         <= '0;
      y_q         <= '0;
      pix_q       <= '0;
      ridx_q      <= '0;
      ret_cnt_q   <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      ret_pipe_q  <= '0;
      level_q     <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      zoom_max_q  <= 1'b0;
      zoom_min_q  <= 1'b0;
    end else begin
      job_q       <= job_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
      ridx_q      <= ridx_d;
      ret_cnt_q   <= ret_cnt_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      ret_pipe_q  <= ret_pipe_d;
      level_q     <= level_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      zoom_max_q  <= zoom_max_d;
      zoom_min_q  <= zoom_min_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_addr   = rd_addr_q;
  assign rd_en     = rd_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign zoom_max  = zoom_max_q;
  assign zoom_min  = zoom_min_q;

endmodule

// File: tb/tb_zoom_engine.sv
// Randomized self-checking bench for zoom_engine on a small 8x4 image with behavioural memories.
module tb_zoom_engine;

  localparam int unsigned W   = 8;
  localparam int unsigned H   = 4;
  localparam int unsigned NP  = W * H;
  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 2;
  localparam int          MAXI = 2;
  localparam int          MAXO = 2;
  localparam logic [7:0]  BRD  = 8'h5A;

  logic          clock;
  logic          reset_n;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic          cmd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          busy;
  logic          done;
  logic          err;
  logic          zoom_max;
  logic          zoom_min;

  zoom_engine #(
    .IMG_W   (W),
    .IMG_H   (H),
    .PIX_W   (8),
    .ADDR_W  (AW),
    .RD_LAT  (LAT),
    .MAX_IN  (MAXI),
    .MAX_OUT (MAXO),
    .BORDER  (BRD)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .zoom_max  (zoom_max),
    .zoom_min  (zoom_min)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Source memory with fixed read latency, destination memory with write/read counters
  logic [7:0] src_mem [NP];
  logic [7:0] dst_mem [NP];
  logic [7:0] exp_mem [NP];
  logic [7:0] lat_pipe [LAT];
  logic       clr_dst;
  int         wr_cnt;
  int         rd_cnt;

  always @(posedge clock) begin
    lat_pipe[0] <= rd_en ? src_mem[rd_addr] : 8'h00;
    for (int i = 1; i < LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
    if (clr_dst) begin
      for (int i = 0; i < NP; i++) dst_mem[i] <= 8'h00;
      wr_cnt <= 0;
      rd_cnt <= 0;
    end else begin
      if (wr_en) begin
        dst_mem[wr_addr] <= wr_data;
        wr_cnt <= wr_cnt + 1;
      end
      if (rd_en) rd_cnt <= rd_cnt + 1;
    end
  end
  assign rd_data = lat_pipe[LAT-1];

  int n_checks;
  int n_fail;
  int level;
  int exp_reads;
  int exp_cycles;
  int last_done_cyc;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int src_at(input int x, input int y);
    return int'(src_mem[y*W + x]);
  endfunction

  // Reference image, read count and cycle count; mode 0 copy, 1 zoom-in, 2 avg, 3 decimate
  task automatic build_expected(input int mode);
    exp_reads  = 0;
    exp_cycles = 1;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int n;
        int v;
        int sx;
        int sy;
        bit in_box;
        in_box = (x >= W/4) && (x < 3*W/4) && (y >= H/4) && (y < 3*H/4);
        sx = 2 * (x - W/4);
        sy = 2 * (y - H/4);
        if (mode == 0) begin
          n = 1; v = src_at(x, y);
        end else if (mode == 1) begin
          n = 1; v = src_at(W/4 + x/2, H/4 + y/2);
        end else if (!in_box) begin
          n = 0; v = int'(BRD);
        end else if (mode == 2) begin
          n = 4;
          v = (src_at(sx, sy) + src_at(sx+1, sy) + src_at(sx, sy+1) + src_at(sx+1, sy+1)) / 4;
        end else begin
          n = 1; v = src_at(sx, sy);
        end
        exp_mem[y*W + x] = 8'(v);
        exp_reads  += n;
        exp_cycles += (n == 0) ? 2 : (n + LAT + 1);
      end
    end
  endtask

  task automatic fill_src_random();
    for (int i = 0; i < NP; i++) src_mem[i] = 8'($urandom);
  endtask

  task automatic clear_dst();
    @(negedge clock);
    clr_dst = 1'b1;
    @(negedge clock);
    clr_dst = 1'b0;
  endtask

  // Issue one command, follow it to done, and compare everything against the model
  task automatic run_and_check(input logic [2:0] op);
    bit work;
    bit exp_err;
    bit err_seen;
    int mode;
    int lvl_next;
    int done_cyc;
    int busy_cyc;
    int cyc;
    work = 0; exp_err = 0; mode = 0; lvl_next = level;
    case (op)
      3'b000: ;
      3'b001: work = 1;
      3'b111: begin work = 1; lvl_next = 0; end
      3'b011, 3'b100: begin
        if (level == MAXI) exp_err = 1;
        else begin work = 1; mode = 1; lvl_next = level + 1; end
      end
      3'b101, 3'b110: begin
        if (level == -MAXO) exp_err = 1;
        else begin work = 1; mode = (op == 3'b101) ? 2 : 3; lvl_next = level - 1; end
      end
      default: exp_err = 1;
    endcase
    if (work) build_expected(mode);
    else begin exp_cycles = 1; exp_reads = 0; end

    clear_dst();
    check_eq($sformatf("op%0d_ready_before", op), int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clock);
    cmd_valid = 1'b0;
    cyc = 1; done_cyc = -1; busy_cyc = 0; err_seen = 0;
    while (cyc <= 2000) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = cyc;
        err_seen = err;
        break;
      end
      if (cyc == 3 && busy) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    cmd_valid = 1'b0;
    last_done_cyc = done_cyc;

    check_eq($sformatf("op%0d_done_cycle", op), done_cyc, exp_cycles);
    check_eq($sformatf("op%0d_busy_cycles", op), busy_cyc, exp_cycles);
    check_eq($sformatf("op%0d_err", op), int'(err_seen), int'(exp_err));
    check_eq($sformatf("op%0d_writes", op), wr_cnt, work ? NP : 0);
    check_eq($sformatf("op%0d_reads", op), rd_cnt, exp_reads);
    if (work) begin
      for (int i = 0; i < NP; i++)
        check_eq($sformatf("op%0d_dst[%0d]", op, i), int'(dst_mem[i]), int'(exp_mem[i]));
    end
    level = lvl_next;
    @(negedge clock);
    @(negedge clock);
    check_eq($sformatf("op%0d_zoom_max", op), int'(zoom_max), int'(level == MAXI));
    check_eq($sformatf("op%0d_zoom_min", op), int'(zoom_min), int'(level == -MAXO));
    check_eq($sformatf("op%0d_ready_after", op), int'(cmd_ready), 1);
  endtask

  initial begin
    int border_ok;
    bit seen;
    n_checks = 0;
    n_fail   = 0;
    level    = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    clr_dst   = 1'b0;
    for (int i = 0; i < NP; i++) src_mem[i] = 8'(i);
    repeat (3) @(negedge clock);

    check_eq("rst_cmd_ready", int'(cmd_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_rd_en", int'(rd_en), 0);
    check_eq("rst_wr_en", int'(wr_en), 0);
    check_eq("rst_rd_addr", int'(rd_addr), 0);
    check_eq("rst_wr_addr", int'(wr_addr), 0);
    check_eq("rst_wr_data", int'(wr_data), 0);
    check_eq("rst_zoom_max", int'(zoom_max), 0);
    check_eq("rst_zoom_min", int'(zoom_min), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Copy of an identity image
    run_and_check(3'b001);
    check_eq("copy_done_129", last_done_cyc, 129);

    // Zoom in twice, then a rejected third zoom in
    run_and_check(3'b011);
    check_eq("zin_dst00", int'(dst_mem[0]), 10);
    check_eq("zin_dst11", int'(dst_mem[9]), 10);
    check_eq("zin_dst73", int'(dst_mem[31]), 21);
    run_and_check(3'b100);
    check_eq("zin_max_set", int'(zoom_max), 1);
    run_and_check(3'b011);
    check_eq("zin_reject_cycle", last_done_cyc, 1);
    run_and_check(3'b111);

    // Averaging zoom out with a known top-left block
    fill_src_random();
    src_mem[0] = 8'd10;
    src_mem[1] = 8'd11;
    src_mem[8] = 8'd19;
    src_mem[9] = 8'd20;
    run_and_check(3'b101);
    check_eq("avg_dst21", int'(dst_mem[10]), 15);
    check_eq("avg_inner_pixels", rd_cnt / 4, 8);
    border_ok = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (!((x >= W/4) && (x < 3*W/4) && (y >= H/4) && (y < 3*H/4)) && dst_mem[y*W + x] == BRD)
          border_ok++;
    check_eq("avg_border_pixels", border_ok, NP - 8);

    // Random command mix including NOP and the illegal opcode
    for (int k = 0; k < 20; k++) begin
      fill_src_random();
      run_and_check(3'($urandom_range(0, 7)));
    end

    // Abort a decimating zoom out at pixel 5 with reset
    run_and_check(3'b111);
    fill_src_random();
    build_expected(3);
    clear_dst();
    cmd_valid = 1'b1;
    cmd_op    = 3'b110;
    @(negedge clock);
    cmd_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      if (wr_en && wr_addr == AW'(5)) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    check_eq("abort_reached_px5", int'(seen), 1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_wr_en", int'(wr_en), 0);
    check_eq("abort_cmd_ready", int'(cmd_ready), 1);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_zoom_min", int'(zoom_min), 0);
    repeat (3) @(negedge clock);
    check_eq("abort_write_count", wr_cnt, 5);
    reset_n = 1'b1;
    level = 0;
    @(negedge clock);
    fill_src_random();
    run_and_check(3'b111);
    run_and_check(3'b110);
    run_and_check(3'b110);
    check_eq("after_abort_zoom_min", int'(zoom_min), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zoom_engine.md
ZOOM_ENGINE -- requirements
Module: zoom_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 320, image width in pixels; even, at least 4.
REQ-002 SHALL have parameter IMG_H, default 240, image height in pixels; even, at least 4.
REQ-003 SHALL have parameter PIX_W, default 8, pixel word width.
REQ-004 SHALL have parameter ADDR_W, default 17, memory address width; 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 SHALL have parameter RD_LAT, default 2, source-memory read latency in cycles, 1..4.
REQ-006 SHALL have parameters MAX_IN, default 2, and MAX_OUT, default 2, zoom level limits.
REQ-007 SHALL have parameter BORDER, default 0, PIX_W-bit fill value for pixels outside a zoomed-out image.
REQ-008 SHALL have port clock, input, 1 bit, sole clock, rising edge.
REQ-009 SHALL have port reset_n, input, 1 bit; one clock, reset asynchronous, active-low.
REQ-010 SHALL have port cmd_valid, input, 1 bit, command request.
REQ-011 SHALL have port cmd_op, input, 3 bits, opcode.
REQ-012 SHALL have port cmd_ready, output, 1 bit, high only in IDLE.
REQ-013 SHALL have port rd_addr, output, ADDR_W bits, source read address.
REQ-014 SHALL have port rd_en, output, 1 bit, source read strobe.
REQ-015 SHALL have port rd_data, input, PIX_W bits, valid RD_LAT cycles after rd_en.
REQ-016 SHALL have ports wr_addr, output, ADDR_W bits; wr_data, output, PIX_W bits; wr_en, output, 1 bit, destination write.
REQ-017 SHALL have ports busy, done, err, zoom_max, zoom_min, outputs, 1 bit each, status.

Function
REQ-018 SHALL accept a command on a clock edge where cmd_valid and cmd_ready are both high; cmd_valid while busy SHALL be ignored.
REQ-019 SHALL decode opcodes: 000 NOP; 001 COPY; 011 ZOOM_IN; 100 ZOOM_IN (alias); 101 ZOOM_OUT_AVG; 110 ZOOM_OUT_DEC; 111 RESET (level forced to 0, then COPY); 010 illegal.
REQ-020 SHALL, for NOP, an illegal opcode, ZOOM_IN at level==MAX_IN, or ZOOM_OUT at level==-MAX_OUT, pulse done one cycle after accept, pulse err with done except for NOP, issue no reads or writes, and leave the level unchanged.
REQ-021 SHALL scan destination pixels in raster order, x fastest, address = y*IMG_W + x, ending at IMG_W*IMG_H-1.
REQ-022 SHALL map ZOOM_IN as dst(x,y) = src(IMG_W/4 + x>>1, IMG_H/4 + y>>1), 1 read per pixel.
REQ-023 SHALL, for ZOOM_OUT modes, define inner region x in [IMG_W/4, 3*IMG_W/4) and y in [IMG_H/4, 3*IMG_H/4), with sx = 2*(x-IMG_W/4) and sy = 2*(y-IMG_H/4).
REQ-024 SHALL write BORDER to pixels outside the inner region, with 0 reads.
REQ-025 SHALL, for ZOOM_OUT_DEC inner pixels, write src(sx,sy), 1 read.
REQ-026 SHALL, for ZOOM_OUT_AVG inner pixels, read (sx,sy), (sx+1,sy), (sx,sy+1), (sx+1,sy+1) in that order, sum at PIX_W+2 bits, and write sum>>2, truncating.
REQ-027 SHALL map COPY as dst(x,y) = src(x,y), 1 read.
REQ-028 SHALL run FSM states IDLE, ISSUE, WAIT, WRITE, FINISH.
REQ-029 SHALL, in ISSUE, assert rd_en for N consecutive cycles, N being the per-pixel read count (0, 1 or 4), then enter WAIT; with N=0 it SHALL go directly to WRITE.
REQ-030 SHALL remain in WAIT until the last datum returns, RD_LAT cycles after its issue, then enter WRITE.
REQ-031 SHALL, in WRITE, assert wr_en for exactly one cycle, then go to ISSUE for the next pixel, or to FINISH after the last pixel.
REQ-032 SHALL, in FINISH, pulse done for one cycle, update the level (ZOOM_IN +1, ZOOM_OUT -1, RESET to 0), and return to IDLE.
REQ-033 SHALL hold busy high from the cycle after accept through FINISH, inclusive.
REQ-034 SHALL drive zoom_max as (level==MAX_IN) and zoom_min as (level==-MAX_OUT), registered from level.
REQ-035 SHALL hold rd_en and wr_en low whenever the FSM is outside ISSUE and WRITE respectively.

Reset
REQ-036 SHALL, on reset_n low, asynchronously force state IDLE, level 0, counters 0, rd_en, wr_en, busy, done and err to 0, addresses and wr_data to 0, cmd_ready to 1, and zoom_max and zoom_min to 0.
REQ-037 SHALL, on reset mid-operation, abort with no further writes; the partial destination image is undefined.

Structure
REQ-038 SHALL place opcodes, the FSM state encoding and the read-count constants in package zoom_pkg.
REQ-039 SHALL implement the coordinate-to-source-address mapping of REQ-022 to REQ-027 in sub-module zoom_addr_gen, combinational, taking (x, y, mode, read index) and returning (addr, inner flag).

Verification
REQ-040 SHALL verify COPY with IMG_W=8, IMG_H=4, RD_LAT=2 and src[i]=i: dst[i]=i for all 32 pixels, done after exactly 32*(1+2+1)+1 cycles of busy.
REQ-041 SHALL verify ZOOM_IN with the same src: dst(0,0)=src(2,1)=10, dst(1,1)=10, dst(7,3)=src(5,2)=21, and level becomes 1.
REQ-042 SHALL verify ZOOM_OUT_AVG with src(0,0..1,1)=10,11,19,20: dst(2,1)=15 (60>>2), every border pixel=BORDER, and the inner pixel count equals 8.
REQ-043 SHALL verify that two ZOOM_IN commands with MAX_IN=2 set zoom_max=1, and that a third yields err+done one cycle after accept, no wr_en, and level 2.
REQ-044 SHALL verify that reset_n asserted at pixel 5 of a ZOOM_OUT_DEC stops wr_en immediately, sets cmd_ready=1 and level 0, and that a following RESET command completes a full COPY.
